// File: rtl/gray_conv_arbiter_if.sv
// Handshake bundle between NUM_REQ binary-word producers, the shared
// gray-conversion arbiter and the single gray-coded consumer.
// The optional out_parity signal exists only when GRAY_ARB_PARITY_EN is defined.
interface gray_conv_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [ID_WIDTH-1:0]           out_id;
`ifdef GRAY_ARB_PARITY_EN
  logic                          out_parity;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_parity
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_parity
  );
`else
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
`endif
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one bin2gray converter among NUM_REQ
// requesters, feeding a one-entry registered output stage tagged with the
// winning requester index.
// Optional feature: define GRAY_ARB_PARITY_EN to add out_parity, the XOR of
// the accepted binary word, registered alongside out_data.

module bin2gray #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

module gray_conv_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_conv_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
`ifdef GRAY_ARB_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic [DATA_WIDTH-1:0] win_bin;
  logic [DATA_WIDTH-1:0] win_gray;
  logic                  can_load;
  logic                  load;

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall (wrap).
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_bin   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req_valid[i] && (i >= int'(ptr_q))) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
        win_bin   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req_valid[i]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
        win_bin   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  bin2gray #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bin2gray (
    .bin  (win_bin),
    .gray (win_gray)
  );

  // Grant and output-stage next state: load whenever the stage can accept and someone is valid.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    id_d          = id_q;
    ptr_d         = ptr_q;
`ifdef GRAY_ARB_PARITY_EN
    par_d         = par_q;
`endif
    bus.req_ready = '0;

    can_load = (state_q == EMPTY) || bus.out_ready;
    load     = can_load && win_found;

    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = load && (win_id == ID_WIDTH'(i));
    end

    if (load) begin
      state_d = FULL;
      data_d  = win_gray;
      id_d    = win_id;
      ptr_d   = (win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
`ifdef GRAY_ARB_PARITY_EN
      par_d   = ^win_bin;
`endif
    end else if ((state_q == FULL) && bus.out_ready) begin
      // Drain only: data/id keep their last values.
      state_d = EMPTY;
    end
  end

  // State, output stage and priority pointer registers; reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef GRAY_ARB_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef GRAY_ARB_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_data   = data_q;
  assign bus.out_id     = id_q;
`ifdef GRAY_ARB_PARITY_EN
  assign bus.out_parity = par_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed vector table, hand-written corner
// sequences and a randomized run checked against a behavioural model.
module tb_gray_conv_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gray_conv_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  gray_conv_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: a one-slot buffer plus a rotating priority index.
  bit         m_full = 1'b0;
  logic [7:0] m_data = '0;
  int         m_id   = 0;
  int         m_ptr  = 0;
  bit         m_par  = 1'b0;

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_can();
    return !m_full || bus.out_ready;
  endfunction

  function automatic logic [3:0] m_ready();
    int w;
    w = m_winner();
    if (m_can() && w >= 0) return 4'(1 << w);
    return 4'b0;
  endfunction

  function automatic logic [7:0] m_word(int i);
    return bus.req_data[i*DW +: DW];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_data <= '0;
      m_id   <= 0;
      m_ptr  <= 0;
      m_par  <= 1'b0;
    end else if (m_can() && m_winner() >= 0) begin
      m_full <= 1'b1;
      m_data <= m_word(m_winner()) ^ (m_word(m_winner()) >> 1);
      m_id   <= m_winner();
      m_ptr  <= (m_winner() + 1) % N;
      m_par  <= ^m_word(m_winner());
    end else if (m_full && bus.out_ready) begin
      m_full <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic r);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    logic [31:0] data;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_vld;
    logic [7:0] exp_data;
    logic [1:0] exp_id;
    logic       exp_par;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b0, 4'b0001, 32'h00000055, 1'b1, 4'b0001, 1'b1, 8'h7F, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 4'b1111, 32'h735B5357, 1'b1, 4'b0001, 1'b1, 8'h7C, 2'd0, 1'b1};
    tbl[2] = '{1'b0, 4'b1111, 32'h735B5357, 1'b1, 4'b0010, 1'b1, 8'h7A, 2'd1, 1'b0};
    tbl[3] = '{1'b0, 4'b1111, 32'h735B5357, 1'b1, 4'b0100, 1'b1, 8'h76, 2'd2, 1'b1};
    tbl[4] = '{1'b0, 4'b1111, 32'h735B5357, 1'b1, 4'b1000, 1'b1, 8'h4A, 2'd3, 1'b1};
    tbl[5] = '{1'b0, 4'b1111, 32'h735B5357, 1'b1, 4'b0001, 1'b1, 8'h7C, 2'd0, 1'b1};

    drive(4'b0, 32'h0, 1'b0);
    #12;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data",  32'(bus.out_data),  32'd0);
    chk("reset_out_id",    32'(bus.out_id),    32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    do_reset();

    // Directed vector table: single request, then four-way rotation and wrap.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].valid, tbl[i].data, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_out_data", i),  32'(bus.out_data),  32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_out_id", i),    32'(bus.out_id),    32'(tbl[i].exp_id));
`ifdef GRAY_ARB_PARITY_EN
      chk($sformatf("tbl%0d_out_parity", i), 32'(bus.out_parity), 32'(tbl[i].exp_par));
`endif
    end

    // Backpressure: FULL with 0x7C from req0, req1 waiting.
    drive(4'b0010, 32'h735B5357, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_out_data",  32'(bus.out_data),  32'h7C);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_release_data",  32'(bus.out_data),  32'h7A);
    chk("bp_release_id",    32'(bus.out_id),    32'd1);

    // Fairness: grant 2, then req0 and req3 contend; req3 must go first.
    drive(4'b0100, 32'h735B5357, 1'b1);
    #1;
    chk("fair_grant2", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1001;
    #1;
    chk("fair_grant3_first", 32'(bus.req_ready), 32'b1000);
    @(posedge clk);
    #1;
    chk("fair_id3", 32'(bus.out_id), 32'd3);
    #1;
    chk("fair_grant0_next", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("fair_id0", 32'(bus.out_id), 32'd0);

    // Asynchronous reset while FULL (ptr currently 1).
    bus.req_valid = 4'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data",  32'(bus.out_data),  32'd0);
    chk("arst_out_id",    32'(bus.out_id),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b1111, 32'h735B5357, 1'b1);
    #1;
    chk("arst_ptr_zero", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
      #1;
      chk("rnd_req_ready", 32'(bus.req_ready), 32'(m_ready()));
      @(posedge clk);
      #1;
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_full));
      if (m_full) begin
        chk("rnd_out_data", 32'(bus.out_data), 32'(m_data));
        chk("rnd_out_id",   32'(bus.out_id),   32'(m_id));
`ifdef GRAY_ARB_PARITY_EN
        chk("rnd_out_parity", 32'(bus.out_parity), 32'(m_par));
`endif
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Round-robin arbiter that shares one bin2gray converter among NUM_REQ requesters. Each requester offers a binary word with a valid/ready handshake. The winner's word is converted through a single internal bin2gray instance and registered into a one-entry output stage, tagged with the requester's index. It sits between multiple binary-pointer/counter producers and a common gray-coded consumer, such as a CDC pointer bus.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, binary/gray word width; passed to bin2gray DATA_WIDTH
ID_WIDTH, 2, width of out_id; must satisfy NUM_REQ <= 2**ID_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester valid
req_ready  output  NUM_REQ  per-requester ready (one-hot or zero)
req_data  input  NUM_REQ*DATA_WIDTH  binary words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  output stage holds a converted word
out_ready  input  1  consumer accepts output
out_data  output  DATA_WIDTH  gray-coded word (registered)
out_id  output  ID_WIDTH  index of the requester that produced out_data

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values: out_valid=0, out_data=0, out_id=0, priority pointer ptr=0. req_ready is combinational and is 0 while out_valid=0 only if no req_valid is asserted.
- Output-stage FSM has two states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- can_load = EMPTY, or (FULL and out_ready).
- Arbitration (combinational):
  - Scan from index ptr upward, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready[i] = can_load and (i == winner). All other bits are 0.
- Handshake on requester i: req_valid[i] and req_ready[i] high at the same edge.
  - On that edge: out_data <= bin2gray(req_data[i]), out_id <= i, out_valid <= 1, ptr <= (i+1) mod NUM_REQ.
  - Gray conversion: g = b ^ (b >> 1).
- Latency: 1 cycle from requester handshake to out_valid.
  - Throughput: 1 word per cycle while out_ready is held high.
- Drain without a new load (FULL, out_ready=1, no req_valid): out_valid <= 0, giving EMPTY. out_data and out_id hold their last values.
- Simultaneous drain and load: stays FULL with the new word. No bubble.
- FULL with out_ready=0:
  - All req_ready are 0.
  - out_data and out_id are stable.
  - ptr does not move.
- ptr advances only on a handshake. An unserved valid is never skipped, so there is no starvation: the worst-case wait is NUM_REQ-1 grants.
- Requesters may drop req_valid before being granted. The arbiter holds no state per requester.
- Pointer wrap: a grant to NUM_REQ-1 sets ptr=0.
- Reset asserted mid-operation: the output is discarded immediately and asynchronously, all registers return to reset values, and a pending word is lost.
- ptr is a ID_WIDTH-bit register. Values >= NUM_REQ are unreachable.

Optional Feature:
Macro GRAY_ARB_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit), registered alongside out_data.
  - out_parity = XOR-reduce of the binary input word accepted on the handshake.
  - Reset value 0. Holds with out_data.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
1. Reset release, then req_valid=4'b0001 with req0=0x55 and out_ready=1. Required: req_ready=0001; next cycle out_valid=1, out_data=0x7F, out_id=0.
2. All four valid with data 0x57, 0x53, 0x5B, 0x73 and out_ready=1. Required: grants 0,1,2,3 on consecutive cycles; out_data 0x7C, 0x7A, 0x76, 0x4A; then the grant wraps to 0.
3. Backpressure: out_ready=0 while FULL with req1 valid. Required: req_ready=0000 and out_data held for 5 cycles. When out_ready=1, the drain and the req1 load happen on the same edge and out_valid stays 1.
4. Fairness: after a grant to 2, req0 and req3 are both valid. Required: req3 is granted before req0.
5. Assert rst_n low mid-transfer while FULL. Required: out_valid, out_data, out_id and ptr go to 0 without waiting for a clk edge.
6. With GRAY_ARB_PARITY_EN defined, input 0x55. Required: out_parity=0. Input 0x57: out_parity=1.
